// File: rtl/conv_expand_if.sv
// Streaming bundle between the expand engine and its host: activation input
// stream and output-pixel stream towards the activation RAM.
interface conv_expand_if #(
  parameter int WIDTH = 16,
  parameter int CHOUT = 128,
  parameter int WOUT  = 32
);
  localparam int PW = $clog2(WOUT * WOUT) + 1;

  logic signed [WIDTH-1:0]       pix;
  logic                          pix_valid;
  logic                          pix_ready;
  logic        [CHOUT*WIDTH-1:0] ofm;
  logic                          ofm_valid;
  logic                          ofm_ready;
  logic        [PW-1:0]          pixel_idx;

  modport master (
    output pix, pix_valid, ofm_ready,
    input  pix_ready, ofm, ofm_valid, pixel_idx
  );

  modport slave (
    input  pix, pix_valid, ofm_ready,
    output pix_ready, ofm, ofm_valid, pixel_idx
  );
endinterface

// File: rtl/conv_expand_engine.sv
// KxK expand-convolution engine: one activation per step against CHOUT taps,
// accumulate over K*K*CHIN steps, then bias + ReLU + rescale/saturate per pixel.
module conv_expand_engine #(
  parameter int WIDTH      = 16,
  parameter int CHIN       = 32,
  parameter int CHOUT      = 128,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 32,
  parameter int FRAC       = 14,
  parameter int NUM_CTX    = 2,
  localparam int CW    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int STEPS = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int AW    = (STEPS > 1) ? $clog2(STEPS) : 1,
  localparam int NPIX  = WOUT * WOUT,
  localparam int PW    = $clog2(NPIX) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CW-1:0]                ctx_sel,
  input  logic                         abort,
  conv_expand_if.slave                 bus,
  output logic [CW+AW-1:0]             weight_addr,
  input  logic [CHOUT*WIDTH-1:0]       ker_in,
  input  logic [CHOUT*2*WIDTH-1:0]     bias_in,
  output logic [CW-1:0]                ctx_out,
  output logic                         busy,
  output logic                         done
);

  localparam int ACCW = 2 * WIDTH + AW;
  localparam int SUMW = ACCW + 1;
  localparam logic [AW-1:0] STEP_LAST = AW'(STEPS - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
  localparam logic signed [SUMW-1:0] MAX_Q = SUMW'((2 ** (WIDTH - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] relu_rescale(input logic signed [SUMW-1:0] s);
    logic signed [SUMW-1:0] q;
    logic        [WIDTH-1:0] r;
    q = s >>> FRAC;
    if (s < 0)          r = '0;
    else if (q > MAX_Q) r = MAX_Q[WIDTH-1:0];
    else                r = q[WIDTH-1:0];
    return r;
  endfunction

  state_t                       state_q, state_d;
  logic [AW-1:0]                step_q, step_d;
  logic [PW-1:0]                pcnt_q, pcnt_d;
  logic [CW-1:0]                ctx_q, ctx_d;
  logic                         clr;

  logic signed [WIDTH-1:0]      pix_p0_q, pix_p0_d;
  logic [CHOUT*WIDTH-1:0]       ker_p0_q, ker_p0_d;
  logic                         vld_p0_q, vld_p0_d;
  logic                         first_p0_q, first_p0_d;
  logic                         last_p0_q, last_p0_d;
  logic [PW-1:0]                pidx_p0_q, pidx_p0_d;

  logic signed [2*WIDTH-1:0]    prod_p1 [CHOUT];
  logic signed [ACCW-1:0]       acc_sum_p1 [CHOUT];
  logic signed [SUMW-1:0]       sum_p1 [CHOUT];
  logic signed [ACCW-1:0]       acc_q [CHOUT];
  logic signed [ACCW-1:0]       acc_d [CHOUT];
  logic [CHOUT*WIDTH-1:0]       ofm_q, ofm_d;
  logic                         ofm_valid_q, ofm_valid_d;
  logic [PW-1:0]                pixel_idx_q, pixel_idx_d;

  logic                         pix_ready;
  logic                         accept;
  logic                         hs;
  logic                         wr;

  assign pix_ready = (state_q == S_RUN) && !(ofm_valid_q && !bus.ofm_ready);
  assign accept    = bus.pix_valid && pix_ready;
  assign hs        = ofm_valid_q && bus.ofm_ready;
  assign wr        = vld_p0_q && last_p0_q && !abort;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pcnt_d  = pcnt_q;
    ctx_d   = ctx_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ctx_d   = ctx_sel;
          step_d  = '0;
          pcnt_d  = '0;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q == PIX_LAST) state_d = S_DRAIN;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last pixel's result is the only one carrying PIX_LAST.
        if (hs && pixel_idx_q == PIX_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      pcnt_d  = '0;
      clr     = 1'b1;
    end
  end

  // Stage P: register the accepted activation and its tap row
  always_comb begin
    vld_p0_d   = accept && !abort;
    pix_p0_d   = accept ? bus.pix : pix_p0_q;
    ker_p0_d   = accept ? ker_in  : ker_p0_q;
    first_p0_d = (step_q == '0);
    last_p0_d  = (step_q == STEP_LAST);
    pidx_p0_d  = pcnt_q;
  end

  // Stage A: multiply-accumulate, and on the last step bias/ReLU/rescale
  always_comb begin
    ofm_d       = ofm_q;
    pixel_idx_d = wr ? pidx_p0_q : pixel_idx_q;
    for (int i = 0; i < CHOUT; i++) begin
      prod_p1[i]    = pix_p0_q * $signed(ker_p0_q[i*WIDTH +: WIDTH]);
      acc_sum_p1[i] = (first_p0_q ? ACCW'(0) : acc_q[i]) + ACCW'(prod_p1[i]);
      sum_p1[i]     = SUMW'(acc_sum_p1[i]) + SUMW'($signed(bias_in[i*2*WIDTH +: 2*WIDTH]));
      if (clr)           acc_d[i] = '0;
      else if (vld_p0_q) acc_d[i] = acc_sum_p1[i];
      else               acc_d[i] = acc_q[i];
      if (wr) ofm_d[i*WIDTH +: WIDTH] = relu_rescale(sum_p1[i]);
    end
    if (abort)   ofm_valid_d = 1'b0;
    else if (wr) ofm_valid_d = 1'b1;
    else if (hs) ofm_valid_d = 1'b0;
    else         ofm_valid_d = ofm_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      pcnt_q      <= '0;
      ctx_q       <= '0;
      vld_p0_q    <= 1'b0;
      first_p0_q  <= 1'b0;
      last_p0_q   <= 1'b0;
      pidx_p0_q   <= '0;
      ofm_q       <= '0;
      ofm_valid_q <= 1'b0;
      pixel_idx_q <= '0;
      for (int i = 0; i < CHOUT; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pcnt_q      <= pcnt_d;
      ctx_q       <= ctx_d;
      vld_p0_q    <= vld_p0_d;
      first_p0_q  <= first_p0_d;
      last_p0_q   <= last_p0_d;
      pidx_p0_q   <= pidx_p0_d;
      ofm_q       <= ofm_d;
      ofm_valid_q <= ofm_valid_d;
      pixel_idx_q <= pixel_idx_d;
      for (int i = 0; i < CHOUT; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_ff @(posedge clk) begin
    pix_p0_q <= pix_p0_d;
    ker_p0_q <= ker_p0_d;
  end

  assign bus.pix_ready = pix_ready;
  assign bus.ofm       = ofm_q;
  assign bus.ofm_valid = ofm_valid_q;
  assign bus.pixel_idx = pixel_idx_q;
  assign weight_addr   = {ctx_q, step_q};
  assign ctx_out       = ctx_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_expand_engine.sv
// Bench for conv_expand_engine: constant-pattern vector table plus randomized
// layers checked against an arithmetic reference of the convolution.
module tb_conv_expand_engine;
  localparam int W     = 16;
  localparam int CHIN  = 2;
  localparam int CHOUT = 4;
  localparam int K     = 3;
  localparam int WOUT  = 2;
  localparam int FRAC  = 14;
  localparam int NCTX  = 2;
  localparam int STEPS = K * K * CHIN;
  localparam int NPIX  = WOUT * WOUT;
  localparam int AW    = 5;
  localparam int CW    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_expand_if #(.WIDTH(W), .CHOUT(CHOUT), .WOUT(WOUT)) bus ();

  logic                   start, abort;
  logic [CW-1:0]          ctx_sel;
  logic [CW+AW-1:0]       weight_addr;
  logic [CHOUT*W-1:0]     ker_in;
  logic [CHOUT*2*W-1:0]   bias_in;
  logic [CW-1:0]          ctx_out;
  logic                   busy, done;

  conv_expand_engine #(
    .WIDTH(W), .CHIN(CHIN), .CHOUT(CHOUT), .KERNEL_DIM(K),
    .WOUT(WOUT), .FRAC(FRAC), .NUM_CTX(NCTX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ctx_sel(ctx_sel), .abort(abort),
    .bus(bus), .weight_addr(weight_addr), .ker_in(ker_in), .bias_in(bias_in),
    .ctx_out(ctx_out), .busy(busy), .done(done)
  );

  logic signed [W-1:0]    act   [NPIX][STEPS];
  logic signed [W-1:0]    rom   [NCTX][2**AW][CHOUT];
  logic signed [2*W-1:0]  bias_t[NCTX][CHOUT];

  logic [AW-1:0] wa_step;
  logic [CW-1:0] wa_ctx;
  assign wa_step = weight_addr[AW-1:0];
  assign wa_ctx  = weight_addr[AW +: CW];

  always_comb begin
    ker_in  = '0;
    bias_in = '0;
    for (int ch = 0; ch < CHOUT; ch++) begin
      ker_in[ch*W +: W]       = rom[wa_ctx][wa_step][ch];
      bias_in[ch*2*W +: 2*W]  = bias_t[ctx_out][ch];
    end
  end

  typedef struct {
    int                 idx;
    logic [CHOUT*W-1:0] ofm;
  } cap_t;
  cap_t cap_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tb_accepts = 0;
  int cur_ctx = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ofm_valid && bus.ofm_ready) cap_q.push_back('{int'(bus.pixel_idx), bus.ofm});
    if (bus.pix_valid && bus.pix_ready) begin
      chk("weight_addr", longint'(weight_addr), longint'(cur_ctx * (2**AW) + tb_accepts % STEPS));
      tb_accepts++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Convolution of one pixel computed straight from the definition
  function automatic logic [W-1:0] model(input int ctx, input int p, input int ch);
    longint s;
    s = longint'(bias_t[ctx][ch]);
    for (int k = 0; k < STEPS; k++) s += longint'(act[p][k]) * longint'(rom[ctx][k][ch]);
    if (s < 0) return '0;
    s = s / (longint'(1) << FRAC);
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  task automatic do_start(input int ctx);
    @(posedge clk); #1;
    ctx_sel    = ctx[CW-1:0];
    start      = 1'b1;
    tb_accepts = 0;
    cur_ctx    = ctx;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int target, input int pct);
    int guard = 0;
    while (tb_accepts < target && guard <= 4000) begin
      bus.pix_valid = ($urandom_range(0, 99) < pct);
      bus.pix       = act[(tb_accepts / STEPS) % NPIX][tb_accepts % STEPS];
      @(posedge clk); #1;
      guard++;
    end
    bus.pix_valid = 1'b0;
    if (guard > 4000) chk("feed_timeout", tb_accepts, target);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_layer(input int ctx, input int pct);
    cap_q.delete();
    do_start(ctx);
    feed(NPIX * STEPS, pct);
    wait_idle(400);
  endtask

  task automatic check_layer(input int ctx, input string tag);
    chk({tag, "_count"}, cap_q.size(), NPIX);
    for (int i = 0; i < cap_q.size() && i < NPIX; i++) begin
      chk({tag, "_pixel_idx"}, cap_q[i].idx, i);
      for (int ch = 0; ch < CHOUT; ch++)
        chk({tag, "_ofm"}, longint'(cap_q[i].ofm[ch*W +: W]), longint'(model(ctx, i, ch)));
    end
  endtask

  task automatic randomize_ctx(input int ctx);
    int r;
    for (int s = 0; s < 2**AW; s++)
      for (int ch = 0; ch < CHOUT; ch++) begin
        r = int'($urandom_range(0, 4095)) - 2048;
        rom[ctx][s][ch] = 16'(r);
      end
    for (int ch = 0; ch < CHOUT; ch++) begin
      r = int'($urandom_range(0, 1 << 29)) - (1 << 28);
      bias_t[ctx][ch] = 32'(r);
    end
  endtask

  task automatic randomize_act();
    for (int p = 0; p < NPIX; p++)
      for (int k = 0; k < STEPS; k++) act[p][k] = 16'($urandom);
  endtask

  typedef struct {
    logic signed [W-1:0]   pix, ker_e, ker_o;
    logic signed [2*W-1:0] bias_e, bias_o;
    logic [W-1:0]          exp_e, exp_o;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [CHOUT*W-1:0] first_ofm;
    int d0;

    vecs[0] = '{16'sh4000, 16'sh4000, 16'sh4000, 32'sd0, 32'sd0, 16'h7FFF, 16'h7FFF};
    vecs[1] = '{16'sh4000, 16'sh0400, -16'sh0400, 32'sd0, 32'sd0, 16'h4800, 16'h0000};
    vecs[2] = '{16'sh2000, 16'sh0100, 16'sh0100, 32'sd268435456, -32'sd268435456, 16'h4900, 16'h0000};
    vecs[3] = '{16'sh0001, 16'sh0001, 16'sh0001, 32'sd16365, 32'sd16366, 16'h0000, 16'h0001};
    vecs[4] = '{-16'sh4000, -16'sh4000, 16'sh4000, 32'sd0, 32'sd0, 16'h7FFF, 16'h0000};
    vecs[5] = '{16'sh4000, 16'sh0000, 16'sh0000, 32'sd536870912, 32'sd536838144, 16'h7FFF, 16'h7FFE};

    rst = 1'b0; start = 1'b0; abort = 1'b0; ctx_sel = '0;
    bus.pix = '0; bus.pix_valid = 1'b0; bus.ofm_ready = 1'b1;
    for (int c = 0; c < NCTX; c++) randomize_ctx(c);
    randomize_act();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_weight_addr", weight_addr, 0);
    chk("rst_ofm", bus.ofm, 0);
    chk("rst_ofm_valid", bus.ofm_valid, 0);
    chk("rst_pixel_idx", bus.pixel_idx, 0);
    chk("rst_ctx_out", ctx_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < NPIX; p++)
        for (int k = 0; k < STEPS; k++) act[p][k] = vecs[v].pix;
      for (int s = 0; s < 2**AW; s++)
        for (int ch = 0; ch < CHOUT; ch++)
          rom[0][s][ch] = (ch % 2 == 0) ? vecs[v].ker_e : vecs[v].ker_o;
      for (int ch = 0; ch < CHOUT; ch++)
        bias_t[0][ch] = (ch % 2 == 0) ? vecs[v].bias_e : vecs[v].bias_o;
      d0 = done_cnt;
      run_layer(0, 100);
      chk("vec_done_count", done_cnt - d0, 1);
      if (v == 0) chk("done_latency", done_cyc - start_cyc, NPIX * STEPS + 3);
      chk("vec_count", cap_q.size(), NPIX);
      for (int i = 0; i < cap_q.size() && i < NPIX; i++)
        for (int ch = 0; ch < CHOUT; ch++)
          chk($sformatf("vec%0d_p%0d_ch%0d", v, i, ch), longint'(cap_q[i].ofm[ch*W +: W]),
              longint'((ch % 2 == 0) ? vecs[v].exp_e : vecs[v].exp_o));
    end

    // Randomized layer, gapless
    randomize_ctx(0);
    randomize_act();
    run_layer(0, 100);
    check_layer(0, "rand_gapless");

    // Same data with ~50% pix_valid gaps
    run_layer(0, 50);
    check_layer(0, "rand_gaps");

    // Output backpressure for 10 cycles after the first result
    randomize_act();
    cap_q.delete();
    bus.ofm_ready = 1'b0;
    do_start(0);
    fork
      feed(NPIX * STEPS, 100);
      begin
        int n = 0;
        while (!bus.ofm_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_valid", bus.ofm_valid, 1);
        first_ofm = bus.ofm;
        repeat (10) begin
          @(negedge clk);
          chk("bp_pix_ready", bus.pix_ready, 0);
          chk("bp_ofm_hold", bus.ofm, first_ofm);
          chk("bp_pixel_idx", bus.pixel_idx, 0);
        end
        @(posedge clk); #1;
        bus.ofm_ready = 1'b1;
      end
    join
    wait_idle(400);
    check_layer(0, "backpressure");

    // Back-to-back layers on two contexts
    randomize_ctx(1);
    randomize_act();
    d0 = done_cnt;
    run_layer(0, 100);
    check_layer(0, "b2b_ctx0");
    chk("b2b_done0", done_cnt - d0, 1);
    d0 = done_cnt;
    run_layer(1, 100);
    check_layer(1, "b2b_ctx1");
    chk("b2b_done1", done_cnt - d0, 1);
    chk("b2b_ctx_out", ctx_out, 1);

    // Abort at step 7 of pixel 1, then a full restart
    d0 = done_cnt;
    cap_q.delete();
    do_start(0);
    feed(STEPS + 7, 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_ofm_valid", bus.ofm_valid, 0);
      chk("abort_busy", busy, 0);
    end
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_pre_results", cap_q.size(), 1);
    run_layer(0, 100);
    check_layer(0, "after_abort");
    chk("after_abort_done", done_cnt - d0, 1);

    // Asynchronous reset mid-layer, then a full run
    do_start(1);
    feed(30, 100);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ofm_valid", bus.ofm_valid, 0);
    chk("arst_pix_ready", bus.pix_ready, 0);
    chk("arst_weight_addr", weight_addr, 0);
    chk("arst_ctx_out", ctx_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_layer(1, 100);
    check_layer(1, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
